// File: rtl/route_alloc.sv
// route_alloc: per-input route capture, per-output round-robin arbitration and packet-long locks.
// Optional lock watchdog is compiled in with `define ROUTE_ALLOC_TIMEOUT_EN.
module route_alloc_lane #(
    parameter int N  = 2,
    parameter int W  = 1,
    parameter int TO = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] dest_i,
    input  logic         last_i,
    input  logic         win_i,
    output logic         req_o,
    output logic         lock_d_o,
    output logic [W-1:0] dest_d_o,
    output logic         lock_o,
    output logic [W-1:0] dest_o,
    output logic         err_o
);
    typedef enum logic [1:0] {IDLE, REQ, LOCKED} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] dest_q, dest_d;
    logic         lock_q;
    logic         err_q, err_d;
    logic         err_seen_q, err_seen_d;
    logic         in_range, fire, timeout;

    assign in_range = {1'b0, dest_i} < (W+1)'(N);
    assign fire     = valid_i & (state_q == LOCKED);
    assign req_o    = (state_q == REQ) & valid_i & in_range;

`ifdef ROUTE_ALLOC_TIMEOUT_EN
    localparam int CW = $clog2(TO + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counts consecutive locked cycles without a transfer.
    always_comb begin
        cnt_d = '0;
        if (state_q == LOCKED && !fire) cnt_d = cnt_q + 1'b1;
    end
    assign timeout = (state_q == LOCKED) && !fire && (cnt_q == CW'(TO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic [31:0] unused_to;
    assign unused_to = TO;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        err_d      = 1'b0;
        err_seen_d = err_seen_q & valid_i;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (in_range) begin
                        state_d = REQ;
                    end else if (!err_seen_q) begin
                        // Bad destination reported once until valid drops.
                        err_d      = 1'b1;
                        err_seen_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (!valid_i) begin
                    state_d = IDLE;
                end else if (win_i) begin
                    state_d = LOCKED;
                    dest_d  = dest_i;
                end
            end
            LOCKED: begin
                if ((fire && last_i) || timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != LOCKED) dest_d = '0;
    end

    assign lock_d_o = (state_d == LOCKED);
    assign dest_d_o = dest_d;
    assign lock_o   = lock_q;
    assign dest_o   = dest_q;
    assign err_o    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dest_q     <= '0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
            err_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            lock_q     <= (state_d == LOCKED);
            err_q      <= err_d;
            err_seen_q <= err_seen_d;
        end
    end
endmodule

module route_alloc #(
    parameter  int number_ports   = 2,
    parameter  int timeout_cycles = 255,
    localparam int W              = $clog2(number_ports)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [number_ports-1:0]   in_valid,
    input  logic [W*number_ports-1:0] in_dest,
    input  logic [number_ports-1:0]   in_last,
    output logic [number_ports-1:0]   grant,
    output logic [W*number_ports-1:0] destinations,
    output logic [number_ports-1:0]   out_busy,
    output logic [number_ports-1:0]   err_dest
);
    localparam int N = number_ports;

    logic [N-1:0]          req, win, lock_d;
    logic [N-1:0][W-1:0]   dest_d;
    logic [N-1:0][W-1:0]   rr_q, rr_d;
    logic [N-1:0]          out_busy_q, out_busy_d;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            route_alloc_lane #(.N(N), .W(W), .TO(timeout_cycles)) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .valid_i  (in_valid[gi]),
                .dest_i   (in_dest[gi*W +: W]),
                .last_i   (in_last[gi]),
                .win_i    (win[gi]),
                .req_o    (req[gi]),
                .lock_d_o (lock_d[gi]),
                .dest_d_o (dest_d[gi]),
                .lock_o   (grant[gi]),
                .dest_o   (destinations[gi*W +: W]),
                .err_o    (err_dest[gi])
            );
        end
    endgenerate

    // Outputs arbitrate independently; a busy output (registered) is never re-granted
    // in the cycle its lock releases.
    always_comb begin
        logic found;
        int   k;
        win   = '0;
        rr_d  = rr_q;
        found = 1'b0;
        k     = 0;
        for (int j = 0; j < N; j++) begin
            found = 1'b0;
            if (!out_busy_q[j]) begin
                for (int o = 0; o < N; o++) begin
                    k = int'(rr_q[j]) + o;
                    if (k >= N) k = k - N;
                    if (!found && req[k] && in_dest[k*W +: W] == W'(j)) begin
                        found   = 1'b1;
                        win[k]  = 1'b1;
                        rr_d[j] = (k == N - 1) ? '0 : W'(k + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        out_busy_d = '0;
        for (int i = 0; i < N; i++) begin
            if (lock_d[i]) out_busy_d[dest_d[i]] = 1'b1;
        end
    end

    assign out_busy = out_busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            out_busy_q <= '0;
        end else begin
            rr_q       <= rr_d;
            out_busy_q <= out_busy_d;
        end
    end
endmodule

// File: tb/tb_route_alloc.sv
// Directed bench for route_alloc: a 4-port instance for routing/arbitration/reset/watchdog
// and a 3-port instance for parallel grants and out-of-range destinations.
module tb_route_alloc;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] v4, l4, g4, b4, e4;
    logic [7:0] d4, o4;
    logic [2:0] v3, l3, g3, b3, e3;
    logic [5:0] d3, o3;

    int tests = 0;
    int fails = 0;

    route_alloc #(.number_ports(4), .timeout_cycles(8)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_dest(d4), .in_last(l4),
        .grant(g4), .destinations(o4), .out_busy(b4), .err_dest(e4)
    );

    route_alloc #(.number_ports(3), .timeout_cycles(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_dest(d3), .in_last(l3),
        .grant(g3), .destinations(o3), .out_busy(b3), .err_dest(e3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] fair_exp [8];
        fair_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010};

        rst_n = 1'b0;
        v4 = '0; l4 = '0; d4 = '0;
        v3 = '0; l3 = '0; d3 = '0;
        tick(); tick();
        chk("rst_grant", g4, 0);
        chk("rst_dest", o4, 0);
        chk("rst_busy", b4, 0);
        chk("rst_err", e4, 0);
        rst_n = 1'b1;
        tick();

        // single route: in0 -> out2, three flits
        v4 = 4'b0001; d4 = 8'h02;
        tick();
        chk("single_req_wait", g4, 0);
        tick();
        chk("single_grant", g4, 4'b0001);
        chk("single_dest", o4, 8'h02);
        chk("single_busy", b4, 4'b0100);
        d4 = 8'h01;
        tick();
        chk("single_dest_hold", o4, 8'h02);
        chk("single_grant_hold", g4, 4'b0001);
        tick();
        l4 = 4'b0001;
        tick();
        chk("single_release_g", g4, 0);
        chk("single_release_b", b4, 0);
        chk("single_release_d", o4, 0);
        v4 = '0; l4 = '0;
        tick();

        // conflict: in0 and in1 -> out3
        v4 = 4'b0011; d4 = 8'h0F;
        tick(); tick();
        chk("conf_grant0", g4, 4'b0001);
        chk("conf_dest0", o4, 8'h03);
        chk("conf_busy", b4, 4'b1000);
        tick();
        chk("conf_in1_wait", o4, 8'h03);
        l4 = 4'b0001;
        tick();
        chk("conf_release", g4, 0);
        chk("conf_dest_gap", o4, 0);
        v4 = 4'b0010; l4 = '0;
        tick();
        chk("conf_grant1", g4, 4'b0010);
        chk("conf_dest1", o4, 8'h0C);
        chk("conf_busy1", b4, 4'b1000);
        l4 = 4'b0010;
        tick();
        chk("conf_release1", g4, 0);
        v4 = '0; l4 = '0;
        tick();

        // fairness: back-to-back single-flit packets to out3
        v4 = 4'b0011; l4 = 4'b0011; d4 = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("fair_%0d", i), g4, fair_exp[i]);
        end
        v4 = 4'b0010;
        tick();
        v4 = '0; l4 = '0;
        tick(); tick();
        chk("fair_idle_g", g4, 0);
        chk("fair_idle_b", b4, 0);

        // asynchronous reset while locked, then rr must be back at 0
        v4 = 4'b0001; d4 = 8'h02;
        tick(); tick();
        chk("arst_pre", g4, 4'b0001);
        #2;
        rst_n = 1'b0; v4 = '0;
        #1;
        chk("arst_grant", g4, 0);
        chk("arst_dest", o4, 0);
        chk("arst_busy", b4, 0);
        tick();
        rst_n = 1'b1;
        v4 = 4'b1010; d4 = 8'hCC;
        tick(); tick();
        chk("arst_rr", g4, 4'b0010);
        l4 = 4'b0010;
        tick();
        v4 = '0; l4 = '0;
        tick(); tick();
        chk("arst_drain", g4, 0);

        // 3 ports: parallel grants, out-of-range request on in2
        v3 = 3'b111; d3 = 6'b11_10_01;
        tick();
        chk("par_err", e3, 3'b100);
        chk("par_wait", g3, 0);
        tick();
        chk("par_grant", g3, 3'b011);
        chk("par_dest", o3, 6'b00_10_01);
        chk("par_busy", b3, 3'b110);
        chk("par_err_once", e3, 0);
        v3 = 3'b011;
        tick();
        chk("par_err_low", e3, 0);
        v3 = 3'b111;
        tick();
        chk("par_err_again", e3, 3'b100);
        tick();
        chk("par_err_pulse", e3, 0);
        l3 = 3'b011;
        tick();
        chk("par_release", g3, 0);
        chk("par_release_b", b3, 0);
        v3 = '0; l3 = '0;
        tick();

        // stalled lock on out1 with in1 waiting
        v4 = 4'b0011; d4 = 8'h05;
        tick(); tick();
        chk("wd_lock", g4, 4'b0001);
        v4 = 4'b0010;
`ifdef ROUTE_ALLOC_TIMEOUT_EN
        repeat (7) tick();
        chk("wd_hold", g4, 4'b0001);
        tick();
        chk("wd_expire", g4, 0);
        chk("wd_free", b4, 0);
        tick();
        chk("wd_next", g4, 4'b0010);
`else
        repeat (12) tick();
        chk("nowd_hold", g4, 4'b0001);
        chk("nowd_busy", b4, 4'b0010);
        v4 = 4'b0011; l4 = 4'b0001;
        tick();
        chk("nowd_release", g4, 0);
        v4 = 4'b0010; l4 = '0;
        tick();
        chk("nowd_next", g4, 4'b0010);
`endif
        l4 = 4'b0010;
        tick();
        chk("wd_final", g4, 0);
        v4 = '0; l4 = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
